inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/fetch_wait_cnt.sv | 38 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
// Holds the FSM state encoding and the SRAM address-bus width.
package inst_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned SramAddrW = 20;
    localparam int unsigned WaitCntW  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StValid
    } fetch_state_e;

endpackage

// File: rtl/fetch_wait_cnt.sv
// SRAM wait-state counter: loads the extra read-cycle count and counts down to zero.
// The zero flag tells the fetch FSM that the read data is ready to capture.
module fetch_wait_cnt
    import inst_fetch_pkg::*;
#(
    parameter int unsigned Width = WaitCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads one word from an asynchronous SRAM per PC handshake
// and presents it to ID with a valid/ready handshake; FLUSH discards any fetch in flight.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_ce,
    input  logic [XLEN-1:0]      pc,
    input  logic                 flush,
    input  logic                 id_ready,
    input  logic [XLEN-1:0]      sram_data,
    output logic [SramAddrW-1:0] sram_addr,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [XLEN-1:0]      inst,
    output logic [XLEN-1:0]      inst_pc,
    output logic                 inst_valid,
    output logic                 inst_adel,
    output logic                 stall_req
);

    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;

    logic cnt_zero;
    logic accept;
    logic capture;
    logic cnt_dec;

    assign accept  = (state_q == StIdle) && pc_ce && !flush;
    assign capture = (state_q == StRead) && cnt_zero && !flush;
    assign cnt_dec = (state_q == StRead) && !cnt_zero && !flush;

    fetch_wait_cnt #(
        .Width (WaitCntW)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (WaitCntW'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= pc;
            end
            if (capture) begin
                inst_q    <= sram_data;
                inst_pc_q <= addr_q;
            end
        end
    end

    // FLUSH overrides everything; a VALID handshake with ID_READY still completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d = StValid;
                end
            end
            StValid: begin
                if (flush || id_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes and stall are gated by reset so they are safe before the first edge.
    always_comb begin
        sram_ce_n  = rst || (state_q != StRead);
        sram_oe_n  = rst || (state_q != StRead);
        sram_we_n  = 1'b1;
        sram_addr  = addr_q[21:2];
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        inst_valid = (state_q == StValid);
        inst_adel  = (state_q == StValid) && (inst_pc_q[1:0] != 2'b00);
        stall_req  = rst || (!flush && !((state_q == StValid) && id_ready));
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table for single fetches, hand sequences for
// flush/reset corner cases, and a zero-wait instance checking back-to-back throughput.
module tb_inst_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        pc_ce_a, flush_a, id_ready_a;
    logic [31:0] pc_a, sram_data_a, inst_a, inst_pc_a;
    logic [19:0] sram_addr_a;
    logic        ce_n_a, oe_n_a, we_n_a, valid_a, adel_a, stall_a;

    logic        pc_ce_b, flush_b, id_ready_b;
    logic [31:0] pc_b, sram_data_b, inst_b, inst_pc_b;
    logic [19:0] sram_addr_b;
    logic        ce_n_b, oe_n_b, we_n_b, valid_b, adel_b, stall_b;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] sram_word(input logic [19:0] a);
        return (a == 20'd0) ? 32'h2408_0001 : {12'hA5C, a};
    endfunction

    assign sram_data_a = sram_word(sram_addr_a);
    assign sram_data_b = sram_word(sram_addr_b);

    inst_fetch #(.WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .pc_ce(pc_ce_a), .pc(pc_a), .flush(flush_a),
        .id_ready(id_ready_a), .sram_data(sram_data_a), .sram_addr(sram_addr_a),
        .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .inst(inst_a),
        .inst_pc(inst_pc_a), .inst_valid(valid_a), .inst_adel(adel_a), .stall_req(stall_a)
    );

    inst_fetch #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .pc_ce(pc_ce_b), .pc(pc_b), .flush(flush_b),
        .id_ready(id_ready_b), .sram_data(sram_data_b), .sram_addr(sram_addr_b),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .inst(inst_b),
        .inst_pc(inst_pc_b), .inst_valid(valid_b), .inst_adel(adel_b), .stall_req(stall_b)
    );

    // PC-stage model for the throughput instance: advance by 4 when not stalled.
    always @(posedge clk) begin
        if (rst) pc_b <= 32'h0;
        else if (!stall_b) pc_b <= pc_b + 32'd4;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          delay;
        logic [19:0] addr;
        logic [31:0] inst;
        logic        adel;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_b[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("inst", inst_a, e.inst);
            chk("inst_pc", inst_pc_a, e.pc);
            chk("inst_adel", {31'd0, adel_a}, {31'd0, e.adel});
        end
    endtask

    task automatic read_checks(input logic [19:0] addr);
        chk("read_ce_n", {31'd0, ce_n_a}, 32'd0);
        chk("read_oe_n", {31'd0, oe_n_a}, 32'd0);
        chk("read_we_n", {31'd0, we_n_a}, 32'd1);
        chk("read_addr", {12'd0, sram_addr_a}, {12'd0, addr});
        chk("read_valid", {31'd0, valid_a}, 32'd0);
        chk("read_stall", {31'd0, stall_a}, 32'd1);
    endtask

    task automatic do_fetch(input vec_t v);
        pc_a = v.pc;
        pc_ce_a = 1'b1;
        flush_a = 1'b0;
        id_ready_a = (v.delay == 0);
        #1;
        chk("idle_stall", {31'd0, stall_a}, 32'd1);
        chk("idle_valid", {31'd0, valid_a}, 32'd0);
        sb_q.push_back('{v.inst, v.pc, v.adel});
        for (int c = 0; c < 2; c++) begin
            edge_();
            pc_ce_a = 1'b0;  // dropping enable mid-fetch must not abort it
            #1;
            read_checks(v.addr);
        end
        edge_();
        chk("valid_rise", {31'd0, valid_a}, 32'd1);
        check_pop();
        chk("valid_stall", {31'd0, stall_a}, (v.delay == 0) ? 32'd0 : 32'd1);
        for (int i = 1; i <= v.delay; i++) begin
            edge_();
            chk("hold_valid", {31'd0, valid_a}, 32'd1);
            chk("hold_inst", inst_a, v.inst);
            chk("hold_pc", inst_pc_a, v.pc);
            if (i == v.delay) begin
                id_ready_a = 1'b1;
                #1;
                chk("accept_stall", {31'd0, stall_a}, 32'd0);
            end else begin
                chk("hold_stall", {31'd0, stall_a}, 32'd1);
            end
        end
        edge_();
        id_ready_a = 1'b0;
        #1;
        chk("post_valid", {31'd0, valid_a}, 32'd0);
        chk("post_stall", {31'd0, stall_a}, 32'd1);
        chk("post_ce_n", {31'd0, ce_n_a}, 32'd1);
    endtask

    initial begin
        int last;
        int nvalid;
        exp_t e;

        vecs[0] = '{32'h0000_0000, 0, 20'h00000, 32'h2408_0001, 1'b0};
        vecs[1] = '{32'h0000_0008, 4, 20'h00002, 32'hA5C0_0002, 1'b0};
        vecs[2] = '{32'h0000_0006, 0, 20'h00001, 32'hA5C0_0001, 1'b1};
        vecs[3] = '{32'hFFC0_0104, 0, 20'h00041, 32'hA5C0_0041, 1'b0};
        vecs[4] = '{32'h0000_0003, 1, 20'h00000, 32'h2408_0001, 1'b1};

        rst = 1'b1;
        pc_ce_a = 1'b1; pc_a = 32'h40; flush_a = 1'b0; id_ready_a = 1'b0;
        pc_ce_b = 1'b0; flush_b = 1'b0; id_ready_b = 1'b1;
        #1;
        chk("rst_comb_ce_n", {31'd0, ce_n_a}, 32'd1);
        chk("rst_comb_stall", {31'd0, stall_a}, 32'd1);
        for (int i = 0; i < 3; i++) edge_();
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_addr", {12'd0, sram_addr_a}, 32'd0);
        chk("rst_inst", inst_a, 32'd0);
        chk("rst_inst_pc", inst_pc_a, 32'd0);
        chk("rst_adel", {31'd0, adel_a}, 32'd0);
        chk("rst_oe_n", {31'd0, oe_n_a}, 32'd1);
        pc_ce_a = 1'b0;

        // Zero-wait throughput: one instruction every three cycles.
        for (int k = 0; k < 5; k++) begin
            e.pc = 32'(k * 4);
            e.inst = sram_word(20'(k));
            e.adel = 1'b0;
            sb_b.push_back(e);
        end
        pc_ce_b = 1'b1;
        rst = 1'b0;
        last = -1;
        nvalid = 0;
        for (int k = 1; k <= 15; k++) begin
            edge_();
            if (valid_b) begin
                nvalid++;
                if (last < 0) chk("b_first_lat", 32'(k), 32'd2);
                else chk("b_gap", 32'(k - last), 32'd3);
                last = k;
                if (sb_b.size() == 0) begin
                    chk("b_sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_inst_pc", inst_pc_b, e.pc);
                    chk("b_inst", inst_b, e.inst);
                end
            end
        end
        pc_ce_b = 1'b0;
        chk("b_count", 32'(nvalid), 32'd5);
        edge_();
        edge_();

        for (int i = 0; i < 5; i++) do_fetch(vecs[i]);

        // Flush in the second READ cycle: 0x10 is dropped, branch target 0x100 fetched.
        pc_a = 32'h10; pc_ce_a = 1'b1;
        edge_();
        chk("fl_addr", {12'd0, sram_addr_a}, 32'h4);
        edge_();
        flush_a = 1'b1; pc_a = 32'h100;
        #1;
        chk("fl_stall", {31'd0, stall_a}, 32'd0);
        chk("fl_valid", {31'd0, valid_a}, 32'd0);
        edge_();
        flush_a = 1'b0;
        #1;
        chk("fl_idle_valid", {31'd0, valid_a}, 32'd0);
        chk("fl_idle_ce_n", {31'd0, ce_n_a}, 32'd1);
        chk("fl_idle_stall", {31'd0, stall_a}, 32'd1);
        sb_q.push_back('{32'hA5C0_0040, 32'h100, 1'b0});
        edge_();
        pc_ce_a = 1'b0;
        #1;
        read_checks(20'h00040);
        edge_();
        read_checks(20'h00040);
        edge_();
        chk("fl_new_valid", {31'd0, valid_a}, 32'd1);
        check_pop();
        id_ready_a = 1'b1;
        #1;
        chk("fl_new_stall", {31'd0, stall_a}, 32'd0);
        edge_();
        id_ready_a = 1'b0;
        #1;
        chk("fl_new_done", {31'd0, valid_a}, 32'd0);

        // Flush while VALID without ready drops the presented instruction.
        pc_a = 32'h20; pc_ce_a = 1'b1;
        sb_q.push_back('{32'hA5C0_0008, 32'h20, 1'b0});
        edge_();
        pc_ce_a = 1'b0;
        edge_();
        edge_();
        check_pop();
        flush_a = 1'b1;
        #1;
        chk("flv_stall", {31'd0, stall_a}, 32'd0);
        edge_();
        flush_a = 1'b0;
        #1;
        chk("flv_valid", {31'd0, valid_a}, 32'd0);

        // Reset while VALID, then fetch resumes from the held PC.
        pc_a = 32'h24; pc_ce_a = 1'b1;
        sb_q.push_back('{32'hA5C0_0009, 32'h24, 1'b0});
        edge_();
        pc_ce_a = 1'b0;
        edge_();
        edge_();
        chk("rv_valid", {31'd0, valid_a}, 32'd1);
        check_pop();
        rst = 1'b1; pc_ce_a = 1'b1;
        #1;
        chk("rv_ce_n", {31'd0, ce_n_a}, 32'd1);
        chk("rv_stall", {31'd0, stall_a}, 32'd1);
        edge_();
        chk("rv_valid_off", {31'd0, valid_a}, 32'd0);
        chk("rv_addr", {12'd0, sram_addr_a}, 32'd0);
        chk("rv_inst", inst_a, 32'd0);
        edge_();
        chk("rv_hold_ce_n", {31'd0, ce_n_a}, 32'd1);
        rst = 1'b0;
        do_fetch('{32'h0000_0024, 0, 20'h00009, 32'hA5C0_0009, 1'b0});

        // Reset mid-READ: no valid pulse afterwards.
        pc_a = 32'h28; pc_ce_a = 1'b1;
        edge_();
        rst = 1'b1;
        #1;
        chk("rr_ce_n", {31'd0, ce_n_a}, 32'd1);
        edge_();
        rst = 1'b0; pc_ce_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_();
            chk("rr_no_valid", {31'd0, valid_a}, 32'd0);
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
